// File: rtl/ysyx_24090012_pkg.sv
// Shared definitions for the ysyx_24090012 fetch front end.
package ysyx_24090012_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        RESP = 2'd1,
        HOLD = 2'd2
    } ifu_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h3000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;

endpackage

// File: rtl/ysyx_24090012_ifu.sv
// Instruction fetch stage: one AR/R read per instruction, valid/ready to IDU,
// redirect on control hazard with wrong-path response squashing.
module ysyx_24090012_ifu
    import ysyx_24090012_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          NUM_W    = 64
) (
    input  logic             clock,
    input  logic             reset,
    output logic             ifu_valid,
    input  logic             ifu_ready,
    output logic [31:0]      inst,
    output logic [31:0]      ifu_to_idu_pc,
    output logic [NUM_W-1:0] num,
    input  logic             control_hazard,
    input  logic [31:0]      branch_target_pc,
    output logic [31:0]      mem_araddr,
    output logic             mem_arvalid,
    input  logic             mem_arready,
    input  logic [31:0]      mem_rdata,
    input  logic [1:0]       mem_rresp,
    input  logic             mem_rvalid,
    output logic             mem_rready,
    output logic [31:0]      fetch_count
);

    localparam logic [NUM_W-1:0] NUM_ONE = {{(NUM_W-1){1'b0}}, 1'b1};

    ifu_state_e       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [NUM_W-1:0] num_cnt_q, num_cnt_d;
    logic             flush_q, flush_d;
    logic [31:0]      araddr_q, araddr_d;
    logic             arvalid_q, arvalid_d;
    logic             rready_q, rready_d;
    logic             valid_q, valid_d;
    logic [31:0]      inst_q, inst_d;
    logic [31:0]      out_pc_q, out_pc_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [31:0]      fcnt_q, fcnt_d;

    logic             ar_fire;
    logic             r_fire;
    logic [NUM_W-1:0] num_inc;

    assign ar_fire = arvalid_q && mem_arready;
    assign r_fire  = rready_q && mem_rvalid;
    // Zero is reserved for "no instruction", so the wrap lands on one.
    assign num_inc = (&num_cnt_q) ? NUM_ONE : num_cnt_q + NUM_ONE;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        num_cnt_d = num_cnt_q;
        flush_d   = flush_q;
        inst_d    = inst_q;
        out_pc_d  = out_pc_q;
        num_d     = num_q;
        fcnt_d    = fcnt_q;

        unique case (state_q)
            REQ: begin
                // Only an AR already on the bus leaves a wrong-path beat behind.
                if (control_hazard && arvalid_q) begin
                    flush_d = 1'b1;
                end
                if (ar_fire) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (r_fire) begin
                    flush_d = 1'b0;
                    if (flush_q || control_hazard) begin
                        state_d = REQ;
                    end else begin
                        inst_d   = (mem_rresp == RESP_OKAY) ? mem_rdata : NOP_INST;
                        out_pc_d = pc_q;
                        num_d    = num_cnt_q;
                        state_d  = HOLD;
                    end
                end else if (control_hazard) begin
                    flush_d = 1'b1;
                end
            end
            HOLD: begin
                if (control_hazard) begin
                    state_d = REQ;
                end else if (ifu_ready) begin
                    pc_d      = pc_q + 32'd4;
                    num_cnt_d = num_inc;
                    fcnt_d    = fcnt_q + 32'd1;
                    state_d   = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase

        if (control_hazard) begin
            pc_d = branch_target_pc;
        end

        arvalid_d = (state_d == REQ);
        rready_d  = (state_d == RESP);
        valid_d   = (state_d == HOLD);
        // A raised AR keeps its address until accepted.
        araddr_d  = (arvalid_q && !mem_arready) ? araddr_q : pc_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= REQ;
            pc_q      <= RESET_PC;
            num_cnt_q <= NUM_ONE;
            flush_q   <= 1'b0;
            araddr_q  <= RESET_PC;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            valid_q   <= 1'b0;
            inst_q    <= '0;
            out_pc_q  <= '0;
            num_q     <= '0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            num_cnt_q <= num_cnt_d;
            flush_q   <= flush_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            out_pc_q  <= out_pc_d;
            num_q     <= num_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign ifu_valid     = valid_q;
    assign inst          = inst_q;
    assign ifu_to_idu_pc = out_pc_q;
    assign num           = num_q;
    assign mem_araddr    = araddr_q;
    assign mem_arvalid   = arvalid_q;
    assign mem_rready    = rready_q;
    assign fetch_count   = fcnt_q;

endmodule

// File: tb/tb_ysyx_24090012_ifu.sv
// Directed bench for ysyx_24090012_ifu with a fetch-stream model and memory slave.
module tb_ysyx_24090012_ifu;

    localparam logic [31:0] RST_PC = 32'h3000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_valid;
    logic        ifu_ready;
    logic [31:0] inst;
    logic [31:0] ifu_to_idu_pc;
    logic [63:0] num;
    logic        control_hazard;
    logic [31:0] branch_target_pc;
    logic [31:0] mem_araddr;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] fetch_count;

    int          n_vec = 0;
    int          n_err = 0;
    int          ar_lat = 0;
    int          ar_count = 0;
    logic [31:0] last_ar_addr = 32'h0;
    logic [31:0] fault_addr = 32'hFFFF_FFFC;

    ysyx_24090012_ifu dut (
        .clock            (clock),
        .reset            (reset),
        .ifu_valid        (ifu_valid),
        .ifu_ready        (ifu_ready),
        .inst             (inst),
        .ifu_to_idu_pc    (ifu_to_idu_pc),
        .num              (num),
        .control_hazard   (control_hazard),
        .branch_target_pc (branch_target_pc),
        .mem_araddr       (mem_araddr),
        .mem_arvalid      (mem_arvalid),
        .mem_arready      (mem_arready),
        .mem_rdata        (mem_rdata),
        .mem_rresp        (mem_rresp),
        .mem_rvalid       (mem_rvalid),
        .mem_rready       (mem_rready),
        .fetch_count      (fetch_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RST_PC) return 32'h0000_0513;
        return {a[15:2], 2'b00, 16'h0513};
    endfunction

    function automatic logic [31:0] exp_inst(input logic [31:0] a);
        return (a == fault_addr) ? 32'h0000_0013 : mem_word(a);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Memory slave: drives on negedge, handshakes complete on the next posedge.
    initial begin : slave
        int          wait_c;
        bit          have;
        logic [31:0] ra;
        wait_c      = 0;
        have        = 0;
        ra          = 0;
        mem_arready = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;
        mem_rresp   = 2'b00;
        forever begin
            @(negedge clock);
            mem_arready = 1'b0;
            mem_rvalid  = 1'b0;
            if (!reset) begin
                have   = 0;
                wait_c = 0;
            end else if (have) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(ra);
                mem_rresp  = (ra == fault_addr) ? 2'b10 : 2'b00;
                if (mem_rready) have = 0;
            end else if (mem_arvalid) begin
                if (wait_c < ar_lat) begin
                    wait_c++;
                end else begin
                    mem_arready  = 1'b1;
                    have         = 1;
                    ra           = mem_araddr;
                    wait_c       = 0;
                    ar_count++;
                    last_ar_addr = mem_araddr;
                end
            end
        end
    end

    // Fetch-stream model: the stream is a PC sequence that steps by 4 on
    // every accepted delivery and jumps to the target on every redirect.
    initial begin : scoreboard
        logic [31:0] e_pc;
        logic [63:0] e_num;
        logic [31:0] e_cnt;
        e_pc  = RST_PC;
        e_num = 64'd1;
        e_cnt = 32'd0;
        forever begin
            @(negedge clock);
            #2;
            if (!reset) begin
                e_pc  = RST_PC;
                e_num = 64'd1;
                e_cnt = 32'd0;
            end else begin
                chk("fetch_count", {32'h0, fetch_count}, {32'h0, e_cnt});
                if (ifu_valid) begin
                    chk("pc", {32'h0, ifu_to_idu_pc}, {32'h0, e_pc});
                    chk("inst", {32'h0, inst}, {32'h0, exp_inst(e_pc)});
                    chk("num", num, e_num);
                    chk("ar_addr", {32'h0, last_ar_addr}, {32'h0, e_pc});
                    chk("no_prefetch", {63'h0, mem_arvalid}, 64'h0);
                end
                if (control_hazard) begin
                    e_pc = branch_target_pc;
                end else if (ifu_valid && ifu_ready) begin
                    e_pc  = e_pc + 32'd4;
                    e_num = (e_num == '1) ? 64'd1 : e_num + 64'd1;
                    e_cnt = e_cnt + 32'd1;
                end
            end
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        step();
        while (!ifu_valid && k < 40) begin
            step();
            k++;
        end
        if (!ifu_valid) chk("wait_valid_timeout", {63'h0, ifu_valid}, 64'h1);
    endtask

    task automatic wait_ar(input int c0);
        int k;
        k = 0;
        while (ar_count <= c0 && k < 40) begin
            step();
            k++;
        end
        if (ar_count <= c0) chk("wait_ar_timeout", 64'(ar_count), 64'(c0 + 1));
    endtask

    task automatic wait_sig(input bit rsel);
        int k;
        k = 0;
        while (!(rsel ? mem_rready : mem_arvalid) && k < 40) begin
            step();
            k++;
        end
        if (!(rsel ? mem_rready : mem_arvalid))
            chk("wait_sig_timeout", {63'h0, rsel ? mem_rready : mem_arvalid}, 64'h1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, {63'h0, ifu_valid}, 64'h0);
        chk({tag, "_arvalid"}, {63'h0, mem_arvalid}, 64'h0);
        chk({tag, "_rready"}, {63'h0, mem_rready}, 64'h0);
        chk({tag, "_inst"}, {32'h0, inst}, 64'h0);
        chk({tag, "_pc"}, {32'h0, ifu_to_idu_pc}, 64'h0);
        chk({tag, "_num"}, num, 64'h0);
        chk({tag, "_fcnt"}, {32'h0, fetch_count}, 64'h0);
    endtask

    initial begin : main
        int c0;
        reset            = 1'b0;
        ifu_ready        = 1'b0;
        control_hazard   = 1'b0;
        branch_target_pc = 32'h0;
        repeat (3) @(negedge clock);
        #1;
        chk_zero("rst");
        reset     = 1'b1;
        ifu_ready = 1'b1;

        wait_valid();
        chk("t1_inst", {32'h0, inst}, 64'h0000_0513);
        chk("t1_pc", {32'h0, ifu_to_idu_pc}, 64'h3000_0000);
        chk("t1_num", num, 64'd1);
        c0 = ar_count;
        wait_ar(c0);
        chk("t1_next_araddr", {32'h0, last_ar_addr}, 64'h3000_0004);

        ifu_ready = 1'b0;
        wait_valid();
        chk("t2_num", num, 64'd2);
        chk("t2_fcnt", {32'h0, fetch_count}, 64'd1);
        c0 = ar_count;
        repeat (5) step();
        chk("t2_no_ar", 64'(ar_count), 64'(c0));
        chk("t2_valid_held", {63'h0, ifu_valid}, 64'h1);
        chk("t2_pc_held", {32'h0, ifu_to_idu_pc}, 64'h3000_0004);
        chk("t2_inst_held", {32'h0, inst}, 64'h0004_0513);
        ifu_ready = 1'b1;

        step();
        wait_sig(1'b1);
        control_hazard   = 1'b1;
        branch_target_pc = 32'h3000_0100;
        c0 = ar_count;
        step();
        control_hazard = 1'b0;
        chk("t3_drop0", {63'h0, ifu_valid}, 64'h0);
        step();
        chk("t3_drop1", {63'h0, ifu_valid}, 64'h0);
        wait_ar(c0);
        chk("t3_araddr", {32'h0, last_ar_addr}, 64'h3000_0100);
        wait_valid();
        chk("t3_pc", {32'h0, ifu_to_idu_pc}, 64'h3000_0100);
        chk("t3_inst", {32'h0, inst}, 64'h0100_0513);

        wait_valid();
        chk("t4_pc", {32'h0, ifu_to_idu_pc}, 64'h3000_0104);
        control_hazard   = 1'b1;
        branch_target_pc = 32'h3000_0200;
        c0 = ar_count;
        step();
        control_hazard = 1'b0;
        chk("t4_valid_drop", {63'h0, ifu_valid}, 64'h0);
        chk("t4_fcnt", {32'h0, fetch_count}, 64'd3);
        wait_ar(c0);
        chk("t4_araddr", {32'h0, last_ar_addr}, 64'h3000_0200);

        fault_addr = 32'h3000_0204;
        wait_valid();
        chk("t5_pre_pc", {32'h0, ifu_to_idu_pc}, 64'h3000_0200);
        wait_valid();
        chk("t5_pc", {32'h0, ifu_to_idu_pc}, 64'h3000_0204);
        chk("t5_inst", {32'h0, inst}, 64'h0000_0013);
        chk("t5_num", num, 64'd5);
        chk("t5_fcnt", {32'h0, fetch_count}, 64'd4);

        ar_lat = 5;
        step();
        wait_sig(1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("t6");
        repeat (2) @(negedge clock);
        #1;
        reset  = 1'b1;
        ar_lat = 0;
        wait_valid();
        chk("t6_pc", {32'h0, ifu_to_idu_pc}, 64'h3000_0000);
        chk("t6_num", num, 64'd1);
        chk("t6_inst", {32'h0, inst}, 64'h0000_0513);
        chk("t6_fcnt", {32'h0, fetch_count}, 64'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
